// File: rtl/fare_frame_rx.sv
// Fare frame receiver: collects ready/fee/station/complete beats from the
// button scanner, validates against the fare table, and presents accepted
// frames through a one-entry valid/ack buffer.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | waiting for rdy_in to start a frame
// S_FEE    | second rdy beat expected, captures fee
// S_STN    | third rdy beat expected, captures station code
// S_CMP    | waiting for cmp_in strobe (bounded by TIMEOUT)
module fare_frame_rx #(
  parameter int TIMEOUT     = 4,
  parameter int CNT_W       = 8,
  parameter int CHECK_TABLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy_in,
  input  logic [7:0]       data_in,
  input  logic             cmp_in,
  output logic [7:0]       fee_out,
  output logic [7:0]       stn_out,
  output logic             frame_vld,
  input  logic             frame_ack,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic             err_ovr,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FEE  = 2'd1;
  localparam logic [1:0] S_STN  = 2'd2;
  localparam logic [1:0] S_CMP  = 2'd3;

  localparam logic [1:0] E_FRAMING = 2'd1;
  localparam logic [1:0] E_TIMEOUT = 2'd2;
  localparam logic [1:0] E_TABLE   = 2'd3;

  // A TIMEOUT of 1 still needs a one-bit counter.
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       fee_sh_q, fee_sh_d;
  logic [7:0]       stn_sh_q, stn_sh_d;
  logic [7:0]       fee_out_q, fee_out_d;
  logic [7:0]       stn_out_q, stn_out_d;
  logic             frame_vld_q, frame_vld_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             err_ovr_q, err_ovr_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             tbl_hit;

  // Fare table lookup on the captured station/fee pair.
  always_comb begin
    tbl_hit = 1'b0;
    case (stn_sh_q)
      8'd1:    tbl_hit = (fee_sh_q == 8'd16);
      8'd2:    tbl_hit = (fee_sh_q == 8'd23);
      8'd3:    tbl_hit = (fee_sh_q == 8'd26);
      8'd4:    tbl_hit = (fee_sh_q == 8'd30);
      8'd5:    tbl_hit = (fee_sh_q == 8'd33);
      8'd6:    tbl_hit = (fee_sh_q == 8'd37);
      8'd7:    tbl_hit = (fee_sh_q == 8'd40);
      8'd23:   tbl_hit = (fee_sh_q == 8'd44);
      default: tbl_hit = 1'b0;
    endcase
  end

  // Next-state logic for the frame FSM, buffer, error reporting and counter.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    fee_sh_d    = fee_sh_q;
    stn_sh_d    = stn_sh_q;
    fee_out_d   = fee_out_q;
    stn_out_d   = stn_out_q;
    frame_vld_d = frame_vld_q;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    err_ovr_d   = err_ovr_q;
    frame_cnt_d = frame_cnt_q;

    // Ack frees the slot; a commit below in the same cycle reloads it.
    if (frame_vld_q && frame_ack) begin
      frame_vld_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (rdy_in) begin
          state_d = S_FEE;
        end
      end
      S_FEE: begin
        if (rdy_in) begin
          fee_sh_d = data_in;
          state_d  = S_STN;
        end else begin
          frame_err_d = 1'b1;
          err_code_d  = E_FRAMING;
          err_ovr_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_STN: begin
        if (rdy_in) begin
          stn_sh_d = data_in;
          tmo_d    = '0;
          state_d  = S_CMP;
        end else begin
          frame_err_d = 1'b1;
          err_code_d  = E_FRAMING;
          err_ovr_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        if (cmp_in && !rdy_in) begin
          state_d = S_IDLE;
          if ((CHECK_TABLE != 0) && !tbl_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = E_TABLE;
            err_ovr_d   = 1'b0;
          end else if (frame_vld_q && !frame_ack) begin
            frame_err_d = 1'b1;
            err_code_d  = E_TABLE;
            err_ovr_d   = 1'b1;
          end else begin
            fee_out_d   = fee_sh_q;
            stn_out_d   = stn_sh_q;
            frame_vld_d = 1'b1;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end else if (cmp_in && rdy_in) begin
          frame_err_d = 1'b1;
          err_code_d  = E_FRAMING;
          err_ovr_d   = 1'b0;
          state_d     = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          frame_err_d = 1'b1;
          err_code_d  = E_TIMEOUT;
          err_ovr_d   = 1'b0;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
    endcase
  end

  // State and output registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      fee_sh_q    <= '0;
      stn_sh_q    <= '0;
      fee_out_q   <= '0;
      stn_out_q   <= '0;
      frame_vld_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      err_ovr_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      fee_sh_q    <= fee_sh_d;
      stn_sh_q    <= stn_sh_d;
      fee_out_q   <= fee_out_d;
      stn_out_q   <= stn_out_d;
      frame_vld_q <= frame_vld_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      err_ovr_q   <= err_ovr_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign fee_out   = fee_out_q;
  assign stn_out   = stn_out_q;
  assign frame_vld = frame_vld_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign err_ovr   = err_ovr_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fare_frame_rx.sv
// Directed bench for fare_frame_rx: default instance, a table-check-off
// instance and a 2-bit counter instance share one stimulus bus, steered by sel.
module tb_fare_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rdy = 1'b0;
  logic       cmp = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] data = 8'd0;
  int         sel = 0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logic [7:0] a_fee, a_stn, b_fee, b_stn, c_fee, c_stn;
  logic       a_vld, a_err, a_ovr, a_busy;
  logic       b_vld, b_err, b_ovr, b_busy;
  logic       c_vld, c_err, c_ovr, c_busy;
  logic [1:0] a_code, b_code, c_code;
  logic [7:0] a_cnt, b_cnt;
  logic [1:0] c_cnt;

  fare_frame_rx #(.TIMEOUT(4), .CNT_W(8), .CHECK_TABLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rdy_in(rdy && sel == 0), .data_in(data),
    .cmp_in(cmp && sel == 0), .fee_out(a_fee), .stn_out(a_stn), .frame_vld(a_vld),
    .frame_ack(ack && sel == 0), .frame_err(a_err), .err_code(a_code), .err_ovr(a_ovr),
    .frame_cnt(a_cnt), .busy(a_busy));

  fare_frame_rx #(.TIMEOUT(4), .CNT_W(8), .CHECK_TABLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rdy_in(rdy && sel == 1), .data_in(data),
    .cmp_in(cmp && sel == 1), .fee_out(b_fee), .stn_out(b_stn), .frame_vld(b_vld),
    .frame_ack(ack && sel == 1), .frame_err(b_err), .err_code(b_code), .err_ovr(b_ovr),
    .frame_cnt(b_cnt), .busy(b_busy));

  fare_frame_rx #(.TIMEOUT(4), .CNT_W(2), .CHECK_TABLE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .rdy_in(rdy && sel == 2), .data_in(data),
    .cmp_in(cmp && sel == 2), .fee_out(c_fee), .stn_out(c_stn), .frame_vld(c_vld),
    .frame_ack(ack && sel == 2), .frame_err(c_err), .err_code(c_code), .err_ovr(c_ovr),
    .frame_cnt(c_cnt), .busy(c_busy));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Three rdy beats (0, fee, station) then the cmp strobe; returns after the
  // edge that consumes cmp so the commit result is already visible.
  task automatic send(input logic [7:0] fee, input logic [7:0] stn, input logic ack_on_cmp);
    rdy = 1'b1; data = 8'd0;  tick();
    data = fee;               tick();
    data = stn;               tick();
    rdy = 1'b0; data = 8'd0; cmp = 1'b1; ack = ack_on_cmp; tick();
    cmp = 1'b0; ack = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1; tick();
    ack = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;

    // Reset
    tick(); tick();
    chk("rst_vld", a_vld, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_code", a_code, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_fee", a_fee, 0);
    rst_n = 1'b1;
    tick();

    // 1: station 1 fee 16 accepted
    send(8'd16, 8'd1, 1'b0);
    chk("t1_vld", a_vld, 1);
    chk("t1_fee", a_fee, 16);
    chk("t1_stn", a_stn, 1);
    chk("t1_cnt", a_cnt, 1);
    chk("t1_noerr", a_err, 0);
    do_ack();
    chk("t1_ack_vld", a_vld, 0);
    chk("t1_hold_fee", a_fee, 16);

    // Stray cmp in IDLE is ignored
    cmp = 1'b1; tick(); cmp = 1'b0;
    chk("stray_err", a_err, 0);
    chk("stray_busy", a_busy, 0);

    // 2: overrun then ack and resend
    send(8'd44, 8'd23, 1'b0);
    chk("t2_fee44", a_fee, 44);
    chk("t2_cnt", a_cnt, 2);
    send(8'd23, 8'd2, 1'b0);
    chk("t2_ovr_err", a_err, 1);
    chk("t2_ovr_code", a_code, 3);
    chk("t2_ovr_flag", a_ovr, 1);
    chk("t2_keep_fee", a_fee, 44);
    chk("t2_keep_cnt", a_cnt, 2);
    tick();
    chk("t2_pulse1", a_err, 0);
    do_ack();
    send(8'd23, 8'd2, 1'b0);
    chk("t2_fee23", a_fee, 23);
    chk("t2_stn2", a_stn, 2);
    chk("t2_cnt3", a_cnt, 3);

    // 3: rdy drops in STN -> framing error, buffer untouched
    rdy = 1'b1; data = 8'd0; tick();
    data = 8'd30;            tick();
    rdy = 1'b0;              tick();
    chk("t3_err", a_err, 1);
    chk("t3_code", a_code, 1);
    chk("t3_vld", a_vld, 1);
    chk("t3_busy", a_busy, 0);
    do_ack();

    // 4: pair not in table
    send(8'd20, 8'd3, 1'b0);
    chk("t4_err", a_err, 1);
    chk("t4_code", a_code, 3);
    chk("t4_ovr", a_ovr, 0);
    chk("t4_vld", a_vld, 0);
    chk("t4_cnt", a_cnt, 3);
    sel = 1;
    send(8'd20, 8'd3, 1'b0);
    chk("t4_nt_vld", b_vld, 1);
    chk("t4_nt_fee", b_fee, 20);
    chk("t4_nt_err", b_err, 0);
    chk("t4_nt_cnt", b_cnt, 1);
    sel = 0;

    // 5: timeout in CMP
    rdy = 1'b1; data = 8'd0; tick();
    data = 8'd30;            tick();
    data = 8'd4;             tick();
    rdy = 1'b0; data = 8'd0;
    n = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      n++;
      if (a_err) seen = 1;
    end
    chk("t5_seen", seen, 1);
    chk("t5_window", (n >= 3 && n <= 4), 1);
    chk("t5_code", a_code, 2);
    chk("t5_busy", a_busy, 0);

    // 5b: ack coincident with commit keeps vld, no overrun
    send(8'd16, 8'd1, 1'b0);
    chk("t5_cnt4", a_cnt, 4);
    send(8'd23, 8'd2, 1'b1);
    chk("t5b_vld", a_vld, 1);
    chk("t5b_fee", a_fee, 23);
    chk("t5b_err", a_err, 0);
    chk("t5b_code", a_code, 2);
    chk("t5b_cnt", a_cnt, 5);

    // 6a: 2-bit counter wraps
    sel = 2;
    for (int i = 0; i < 4; i++) begin
      send(8'd16, 8'd1, 1'b0);
      do_ack();
    end
    chk("t6_wrap0", c_cnt, 0);
    send(8'd16, 8'd1, 1'b0);
    chk("t6_wrap1", c_cnt, 1);
    sel = 0;

    // 6b: async reset mid-FEE clears everything at once
    rdy = 1'b1; data = 8'd0; tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", a_vld, 0);
    chk("t6_rst_fee", a_fee, 0);
    chk("t6_rst_cnt", a_cnt, 0);
    chk("t6_rst_code", a_code, 0);
    chk("t6_rst_busy", a_busy, 0);
    rdy = 1'b0;
    tick();
    chk("t6_rst_err", a_err, 0);
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
